// File: rtl/program_loader_ctrl_if.sv
// Bundle between the program loader, the UART RX byte stream, the program memory write port
// and the core control lines. The controller uses the master view; its environment uses slave.
interface program_loader_ctrl_if;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_write_address;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      input  start, rx_valid, rx_data,
      output rx_ready, mem_write_enable, mem_write_data, mem_write_address,
      output cpu_hold, busy, done, error
   );

   modport slave (
      output start, rx_valid, rx_data,
      input  rx_ready, mem_write_enable, mem_write_data, mem_write_address,
      input  cpu_hold, busy, done, error
   );
endinterface

// File: rtl/program_loader_ctrl.sv
// Clears program memory, then loads a length-prefixed little-endian word image from a byte stream.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader_ctrl #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   program_loader_ctrl_if.master bus
);
   localparam int WCW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE, S_ERROR
   } state_t;

   state_t           r_state, w_state_next;
   logic [WCW-1:0]   r_cnt, w_cnt_next;
   logic [1:0]       r_byte, w_byte_next;
   logic [15:0]      r_len, w_len_next;
   logic [23:0]      r_word, w_word_next;
   logic             r_rx_ready, w_rx_ready_next;
   logic             r_we, w_we_next;
   logic [31:0]      r_wdata, w_wdata_next;
   logic [31:0]      r_waddr, w_waddr_next;
   logic             r_cpu_hold, w_cpu_hold_next;
   logic             r_busy, w_busy_next;
   logic             r_done, w_done_next;
   logic             r_error, w_error_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]       r_csum, w_csum_next;
`endif

   logic             w_accept;
   logic [15:0]      w_len_full;
   logic [31:0]      w_addr;

   // rx_ready is a register that mirrors the state, so acceptance needs no extra decode.
   assign w_accept   = bus.rx_valid && r_rx_ready;
   assign w_len_full = {bus.rx_data, r_len[7:0]};
   assign w_addr     = BASE_ADDR + (32'(r_cnt) << 2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_byte     <= '0;
         r_len      <= '0;
         r_word     <= '0;
         r_rx_ready <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_waddr    <= '0;
         r_cpu_hold <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_byte     <= w_byte_next;
         r_len      <= w_len_next;
         r_word     <= w_word_next;
         r_rx_ready <= w_rx_ready_next;
         r_we       <= w_we_next;
         r_wdata    <= w_wdata_next;
         r_waddr    <= w_waddr_next;
         r_cpu_hold <= w_cpu_hold_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
         r_error    <= w_error_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         r_csum     <= w_csum_next;
`endif
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_byte_next     = r_byte;
      w_len_next      = r_len;
      w_word_next     = r_word;
      w_we_next       = 1'b0;
      w_wdata_next    = r_wdata;
      w_waddr_next    = r_waddr;
      w_cpu_hold_next = r_cpu_hold;
      w_done_next     = 1'b0;
      w_error_next    = r_error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      w_csum_next     = r_csum;
`endif
      case (r_state)
         S_IDLE, S_ERROR: begin
            if (bus.start) begin
               w_state_next    = S_CLEAR;
               w_cnt_next      = '0;
               w_error_next    = 1'b0;
               w_cpu_hold_next = 1'b1;
            end
         end
         S_CLEAR: begin
            w_we_next    = 1'b1;
            w_wdata_next = '0;
            w_waddr_next = w_addr;
            if (r_cnt == WCW'(DEPTH - 1)) begin
               w_state_next = S_LEN_LO;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_LEN_LO: begin
            if (w_accept) begin
               w_len_next[7:0] = bus.rx_data;
               w_state_next    = S_LEN_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               w_csum_next     = bus.rx_data;
`endif
            end
         end
         S_LEN_HI: begin
            if (w_accept) begin
               w_len_next  = w_len_full;
               w_byte_next = '0;
               w_cnt_next  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               w_csum_next = r_csum ^ bus.rx_data;
`endif
               if (w_len_full == 16'd0) begin
                  w_state_next = S_DONE;
               end else if (32'(w_len_full) > 32'(DEPTH)) begin
                  w_state_next = S_ERROR;
                  w_error_next = 1'b1;
               end else begin
                  w_state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_accept) begin
               w_byte_next = r_byte + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               w_csum_next = r_csum ^ bus.rx_data;
`endif
               if (r_byte == 2'd3) begin
                  w_we_next    = 1'b1;
                  w_wdata_next = {bus.rx_data, r_word};
                  w_waddr_next = w_addr;
                  w_cnt_next   = r_cnt + 1'b1;
                  if (32'(r_cnt) + 32'd1 == 32'(r_len)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     w_state_next = S_CSUM;
`else
                     w_state_next = S_DONE;
`endif
                  end
               end else begin
                  w_word_next[8*r_byte +: 8] = bus.rx_data;
               end
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (w_accept) begin
               if (bus.rx_data == r_csum) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_ERROR;
                  w_error_next = 1'b1;
               end
            end
         end
`endif
         S_DONE: begin
            w_done_next     = 1'b1;
            w_cpu_hold_next = 1'b0;
            w_state_next    = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      w_busy_next     = (w_state_next != S_IDLE) && (w_state_next != S_ERROR);
      w_rx_ready_next = (w_state_next == S_LEN_LO) || (w_state_next == S_LEN_HI) ||
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        (w_state_next == S_CSUM) ||
`endif
                        (w_state_next == S_DATA);
   end

   assign bus.rx_ready          = r_rx_ready;
   assign bus.mem_write_enable  = r_we;
   assign bus.mem_write_data    = r_wdata;
   assign bus.mem_write_address = r_waddr;
   assign bus.cpu_hold          = r_cpu_hold;
   assign bus.busy              = r_busy;
   assign bus.done              = r_done;
   assign bus.error             = r_error;
endmodule
